ldm_stm_seq: RTL
================

Name: ldm_stm_seq

Overview:
- Multi-cycle sequencer for ARM LDM/STM (block data transfer) in the pipelined core.
- Drives the register file write port (we3/wa3/wd3) and its rd2 read port (ra2).
- Drives the data-memory interface one word per cycle, and holds the pipeline stalled via busy until the transfer list and optional base writeback complete.
- Data memory reads combinationally and writes synchronously.

Parameters:
DW, 32, data/address width in bits
NREGS, 16, register-list width (R0..R15)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle request; sampled only in IDLE
is_load  in  1  1 = LDM, 0 = STM
pre  in  1  P bit: 1 = increment/decrement before transfer
up  in  1  U bit: 1 = ascending, 0 = descending
wb  in  1  W bit: write final address back to Rn
rn  in  4  base register index
reglist  in  NREGS  register list, bit i = Ri
base  in  DW  Rn value at start
ra2  out  4  register-file read address (STM source)
rd2  in  DW  register-file read data (r15 supplied by the register file)
we3  out  1  register-file write enable
wa3  out  4  register-file write address
wd3  out  DW  register-file write data, also PC data when pc_we=1
pc_we  out  1  load R15 from wd3 (register file holds no R15)
mem_addr  out  DW  word address
mem_we  out  1  memory write strobe
mem_wdata  out  DW  store data
mem_rdata  in  DW  combinational load data for mem_addr
busy  out  1  stall request
done  out  1  one-cycle completion pulse

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0: ra2, wa3, wd3, mem_addr, mem_wdata, we3, mem_we, pc_we, busy, done.
- Reset mid-operation:
  - Aborts the sequence.
  - No write of any kind in the following cycle.
- States: IDLE, XFER, WBK, DONE.
- IDLE + start:
  - Latch is_load, rn, reglist, and wb_val.
  - Compute N = popcount(reglist).
  - Load the address register:
    - IA (P=0, U=1): base
    - IB (P=1, U=1): base+4
    - DA (P=0, U=0): base-4N+4
    - DB (P=1, U=0): base-4N
  - wb_val = U ? base+4N : base-4N, modulo 2^DW.
  - Next state is XFER if N>0, else DONE (no transfers, no writeback).
- start outside IDLE is ignored.
- busy = 1 in XFER and WBK; 0 in IDLE and DONE.
- XFER (one cycle per register):
  - r = lowest set bit of the remaining list.
  - mem_addr = addr register.
  - STM: ra2 = r, mem_we = 1, mem_wdata = rd2.
  - LDM: wa3 = r, wd3 = mem_rdata, we3 = (r != 15), pc_we = (r == 15).
  - At the clock edge: clear bit r, addr += 4.
  - Registers always transfer in ascending index order at ascending addresses.
- After the last bit:
  - Go to WBK if wb=1, rn != 15, and NOT (is_load and reglist[rn]).
  - Otherwise go to DONE.
- LDM with Rn in the list: the loaded value wins and writeback is suppressed.
- STM with Rn in the list: stores the original register value; writeback still occurs in WBK.
- WBK: we3 = 1, wa3 = rn, wd3 = wb_val; next state DONE.
- DONE: done = 1 for exactly one cycle; next state IDLE.
- Outside the active cycles above, we3, mem_we and pc_we are 0.
- Latency: done asserts in cycle start+N+W'+1, where W' = 1 if WBK is taken, else 0.
- A new start is accepted in the cycle after DONE.
- Address wrap modulo 2^DW; no alignment check (the base is word-aligned by convention).

Test Plan:
- STMIA, base=0x100, reglist=0x000E, R1..R3=11,22,33, wb=1 -> mem[0x100]=11, mem[0x104]=22, mem[0x108]=33; R(rn)=0x10C; done at start+5.
- LDMDB, base=0x200, reglist=0x8003, mem[0x1F4]=7, mem[0x1F8]=8, mem[0x1FC]=0x40, wb=0 -> R0=7, R1=8; pc_we with wd3=0x40; we3 never set for index 15; done at start+4.
- LDMIA, rn=2, reglist=0x0004, wb=1, mem[base]=0x55 -> R2=0x55; no WBK cycle; done at start+2.
- reglist=0, start=1 -> no we3/mem_we; busy stays 0; done at start+1.
- STMIB with N=4, reset asserted during the second XFER cycle -> only one memory write issued; all outputs 0 the next cycle; a subsequent start behaves normally.
- start pulsed during XFER -> ignored; the original sequence completes unchanged; the second request needs a new start after DONE.

Source files
------------

// File: rtl/ldm_stm_seq.sv
// Purpose : sequencer for ARM LDM/STM block transfers. It moves one register per cycle between the
//           register file and data memory, then optionally writes the final address back to Rn.
// Latency : done pulses N + W' + 1 cycles after start (N = registers in list, W' = 1 if writeback taken).
// Backpressure: none accepted. busy stalls the pipeline during XFER/WBK, and start is ignored outside IDLE.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start, is_load, pre, up,   request and LDM/STM mode bits (P, U, W), sampled only in IDLE
//   wb, rn, reglist, base
//   ra2 / rd2                  register-file read port (STM store data)
//   we3, wa3, wd3, pc_we       register-file write port, plus R15 load strobe
//   mem_addr, mem_we,          word-per-cycle data-memory port (combinational read data)
//   mem_wdata, mem_rdata
//   busy, done                 pipeline stall request, one-cycle completion pulse
module ldm_stm_seq #(
    parameter int DW    = 32,
    parameter int NREGS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_load,
    input  logic             pre,
    input  logic             up,
    input  logic             wb,
    input  logic [3:0]       rn,
    input  logic [NREGS-1:0] reglist,
    input  logic [DW-1:0]    base,
    output logic [3:0]       ra2,
    input  logic [DW-1:0]    rd2,
    output logic             we3,
    output logic [3:0]       wa3,
    output logic [DW-1:0]    wd3,
    output logic             pc_we,
    output logic [DW-1:0]    mem_addr,
    output logic             mem_we,
    output logic [DW-1:0]    mem_wdata,
    input  logic [DW-1:0]    mem_rdata,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(NREGS + 1);

    typedef enum logic [1:0] {IDLE, XFER, WBK, DONE} state_t;

    state_t            state;
    logic              is_load_q;
    logic [3:0]        rn_q;
    logic [NREGS-1:0]  remaining;
    logic [DW-1:0]     addr;
    logic [DW-1:0]     wb_val;
    logic              wb_take;

    logic [CW-1:0]     cnt;
    logic [DW-1:0]     four_n;
    logic [DW-1:0]     start_addr;
    logic [3:0]        r_idx;
    logic [NREGS-1:0]  rest;

    // Register count and the first transfer address. The lowest register always goes to the lowest
    // address, so descending modes start 4N below the top of the block.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            cnt = cnt + CW'(reglist[i]);
        end
        four_n = DW'(cnt) << 2;
        case ({pre, up})
            2'b01:   start_addr = base;
            2'b11:   start_addr = base + DW'(4);
            2'b00:   start_addr = base - four_n + DW'(4);
            default: start_addr = base - four_n;
        endcase
    end

    // Lowest set bit of the remaining list. The loop runs downward so that the lowest index wins.
    always_comb begin
        r_idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (remaining[i]) begin
                r_idx = 4'(i);
            end
        end
        rest = remaining & ~(NREGS'(1) << r_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            is_load_q <= 1'b0;
            rn_q      <= '0;
            remaining <= '0;
            addr      <= '0;
            wb_val    <= '0;
            wb_take   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        is_load_q <= is_load;
                        rn_q      <= rn;
                        remaining <= reglist;
                        addr      <= start_addr;
                        wb_val    <= up ? (base + four_n) : (base - four_n);
                        // For LDM with Rn in the list, the loaded value wins. Writing back R15
                        // through the register file is never allowed.
                        wb_take   <= wb && (rn != 4'hF) && !(is_load && reglist[rn]);
                        state     <= (cnt != '0) ? XFER : DONE;
                    end
                end
                XFER: begin
                    remaining <= rest;
                    addr      <= addr + DW'(4);
                    if (rest == '0) begin
                        state <= wb_take ? WBK : DONE;
                    end
                end
                WBK:     state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode the registered state. Store data and load data pass straight through, because
    // rd2 and mem_rdata answer ra2/mem_addr in the same cycle. Write strobes are masked while reset
    // is high, so an aborted sequence cannot land a write on the reset edge.
    always_comb begin
        ra2       = '0;
        we3       = 1'b0;
        wa3       = '0;
        wd3       = '0;
        pc_we     = 1'b0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            XFER: begin
                busy     = 1'b1;
                mem_addr = addr;
                if (is_load_q) begin
                    wa3   = r_idx;
                    wd3   = mem_rdata;
                    we3   = (r_idx != 4'hF) && !reset;
                    pc_we = (r_idx == 4'hF) && !reset;
                end else begin
                    ra2       = r_idx;
                    mem_we    = !reset;
                    mem_wdata = rd2;
                end
            end
            WBK: begin
                busy = 1'b1;
                we3  = !reset;
                wa3  = rn_q;
                wd3  = wb_val;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
